// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: shared opcodes, field encodings and the pipelined control word
package rv32_ctrl_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // ALU ops are {funct7[5], funct3}; PASSB is an otherwise unused code for LUI
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    typedef struct packed {
        logic [2:0] imm_sel;
        logic       asel;
        logic       bsel;
        logic [3:0] alu_sel;
        logic       br_un;
        logic       branch;
        logic       jump;
        logic       mem_rw;
        logic       mem_rd;
        logic [1:0] wb_sel;
        logic       reg_wen;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;
endpackage

// File: rtl/rv32_decode.sv
// rv32_decode: combinational RV32I instruction to control word decoder
module rv32_decode
    import rv32_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_word_t  ctrl,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        illegal
);
    logic [6:0] opcode;
    logic [2:0] f3;
    logic       f7b;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign f3          = inst[14:12];
    assign f7b         = inst[30];
    assign unused_bits = ^{inst[31], inst[29:15]};

    // Per-opcode control word; anything unrecognised stays a NOP and is flagged
    always_comb begin
        ctrl     = CTRL_NOP;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_LUI: begin
                ctrl.imm_sel = IMM_U; ctrl.bsel = 1'b1; ctrl.alu_sel = ALU_PASSB;
                ctrl.wb_sel = WB_ALU; ctrl.reg_wen = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.imm_sel = IMM_U; ctrl.asel = 1'b1; ctrl.bsel = 1'b1;
                ctrl.wb_sel = WB_ALU; ctrl.reg_wen = 1'b1;
            end
            OP_JAL: begin
                ctrl.imm_sel = IMM_J; ctrl.asel = 1'b1; ctrl.bsel = 1'b1; ctrl.jump = 1'b1;
                ctrl.wb_sel = WB_PC4; ctrl.reg_wen = 1'b1;
            end
            OP_JALR: begin
                ctrl.imm_sel = IMM_I; ctrl.bsel = 1'b1; ctrl.jump = 1'b1;
                ctrl.wb_sel = WB_PC4; ctrl.reg_wen = 1'b1; uses_rs1 = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.imm_sel = IMM_B; ctrl.asel = 1'b1; ctrl.bsel = 1'b1; ctrl.branch = 1'b1;
                ctrl.br_un = f3[1]; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OP_LOAD: begin
                ctrl.imm_sel = IMM_I; ctrl.bsel = 1'b1; ctrl.mem_rd = 1'b1;
                ctrl.wb_sel = WB_MEM; ctrl.reg_wen = 1'b1; uses_rs1 = 1'b1;
            end
            OP_STORE: begin
                ctrl.imm_sel = IMM_S; ctrl.bsel = 1'b1; ctrl.mem_rw = 1'b1;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OP_IMM: begin
                ctrl.imm_sel = IMM_I; ctrl.bsel = 1'b1; ctrl.alu_sel = {f3 == 3'b101 && f7b, f3};
                ctrl.wb_sel = WB_ALU; ctrl.reg_wen = 1'b1; uses_rs1 = 1'b1;
            end
            OP_OP: begin
                ctrl.alu_sel = {f7b, f3}; ctrl.wb_sel = WB_ALU; ctrl.reg_wen = 1'b1;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (inst[11:7] == 5'd0) ctrl.reg_wen = 1'b0;
    end
endmodule

// File: rtl/rv32_pipe_ctrl.sv
// rv32_pipe_ctrl: five-stage RV32I control pipeline with branch, stall and forwarding control
module rv32_pipe_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1,
    parameter int RA_W   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     id_inst,
    input  logic            id_valid,
    input  logic            brEq,
    input  logic            brLT,
    output logic [2:0]      id_imm_sel,
    output logic            id_illegal,
    output logic            ex_asel,
    output logic            ex_bsel,
    output logic [3:0]      ex_alu_sel,
    output logic            ex_br_un,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            pcSel,
    output logic            stall_if,
    output logic            flush_id,
    output logic            mem_rw,
    output logic            mem_rd,
    output logic [1:0]      wb_sel,
    output logic            wb_reg_wen,
    output logic [RA_W-1:0] wb_rd
);
    typedef struct packed {
        logic            valid;
        ctrl_word_t      ctrl;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [2:0]      funct3;
    } stage_t;

    ctrl_word_t id_ctrl;
    logic       id_uses_rs1, id_uses_rs2, id_bad;
    stage_t     id_s, ex, mem, wb;
    logic       ex_hit, mem_hit, hazard, taken;
    logic       unused_wb;

    rv32_decode u_decode (
        .inst     (id_inst),
        .ctrl     (id_ctrl),
        .uses_rs1 (id_uses_rs1),
        .uses_rs2 (id_uses_rs2),
        .illegal  (id_bad)
    );

    function automatic logic [1:0] fwd_src(input logic [RA_W-1:0] rs, input stage_t m, input stage_t w);
        if (!FWD_EN || rs == '0) return FWD_RF;
        if (m.ctrl.reg_wen && m.rd == rs) return FWD_MEM;
        if (w.ctrl.reg_wen && w.rd == rs) return FWD_WB;
        return FWD_RF;
    endfunction

    // ID slot as it would enter ID/EX; unused source fields are zeroed so they never match
    always_comb begin
        id_s = '0;
        if (id_valid && !id_bad) begin
            id_s.valid  = 1'b1;
            id_s.ctrl   = id_ctrl;
            id_s.rd     = RA_W'(id_inst[11:7]);
            id_s.rs1    = id_uses_rs1 ? RA_W'(id_inst[19:15]) : '0;
            id_s.rs2    = id_uses_rs2 ? RA_W'(id_inst[24:20]) : '0;
            id_s.funct3 = id_inst[14:12];
        end
    end

    assign ex_hit  = ex.ctrl.reg_wen && (id_s.rs1 == ex.rd || id_s.rs2 == ex.rd);
    assign mem_hit = mem.ctrl.reg_wen && (id_s.rs1 == mem.rd || id_s.rs2 == mem.rd);
    assign hazard  = FWD_EN ? (ex_hit && ex.ctrl.mem_rd) : (ex_hit || mem_hit);
    assign taken   = ex.funct3[2] ? (brLT ^ ex.funct3[0]) : (brEq ^ ex.funct3[0]);
    assign pcSel   = ex.valid && (ex.ctrl.jump || (ex.ctrl.branch && taken));
    assign stall_if = hazard && !pcSel;
    assign flush_id = pcSel;
    assign fwd_a    = fwd_src(ex.rs1, mem, wb);
    assign fwd_b    = fwd_src(ex.rs2, mem, wb);

    // Stage registers always advance; a redirect or stall turns the ID slot into a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex  <= '0;
            mem <= '0;
            wb  <= '0;
        end else begin
            ex  <= (pcSel || hazard) ? '0 : id_s;
            mem <= ex;
            wb  <= mem;
        end
    end

    assign id_imm_sel = rst ? 3'd0 : id_ctrl.imm_sel;
    assign id_illegal = id_valid && id_bad && !rst;
    assign ex_asel    = ex.ctrl.asel;
    assign ex_bsel    = ex.ctrl.bsel;
    assign ex_alu_sel = ex.ctrl.alu_sel;
    assign ex_br_un   = ex.ctrl.br_un;
    assign mem_rw     = mem.ctrl.mem_rw;
    assign mem_rd     = mem.ctrl.mem_rd;
    assign wb_sel     = wb.ctrl.wb_sel;
    assign wb_reg_wen = wb.ctrl.reg_wen;
    assign wb_rd      = wb.rd;
    assign unused_wb  = ^{wb.valid, wb.ctrl, wb.rs1, wb.rs2, wb.funct3};
endmodule

// File: tb/tb_rv32_pipe_ctrl.sv
// tb_rv32_pipe_ctrl: directed checks of decode, hazards, forwarding and redirects for both datapath variants
module tb_rv32_pipe_ctrl;
    localparam logic [31:0] I_LW    = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] I_ADD   = 32'h00728333; // add x6,x5,x7
    localparam logic [31:0] I_ADDI  = 32'h00100093; // addi x1,x0,1
    localparam logic [31:0] I_ADD2  = 32'h00108133; // add x2,x1,x1
    localparam logic [31:0] I_BEQ   = 32'h00108463; // beq x1,x1,+8
    localparam logic [31:0] I_SW    = 32'h0020A023; // sw x2,0(x1)
    localparam logic [31:0] I_LUI   = 32'h000012B7; // lui x5,1
    localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] id_inst = I_BAD;
    logic        id_valid = 1'b1, brEq = 1'b0, brLT = 1'b0;
    int          checks = 0, errors = 0;

    logic [2:0] d1_id_imm_sel, d0_id_imm_sel;
    logic       d1_id_illegal, d0_id_illegal, d1_ex_asel, d0_ex_asel, d1_ex_bsel, d0_ex_bsel;
    logic [3:0] d1_ex_alu_sel, d0_ex_alu_sel;
    logic       d1_ex_br_un, d0_ex_br_un;
    logic [1:0] d1_fwd_a, d0_fwd_a, d1_fwd_b, d0_fwd_b;
    logic       d1_pcSel, d0_pcSel, d1_stall_if, d0_stall_if, d1_flush_id, d0_flush_id;
    logic       d1_mem_rw, d0_mem_rw, d1_mem_rd, d0_mem_rd;
    logic [1:0] d1_wb_sel, d0_wb_sel;
    logic       d1_wb_reg_wen, d0_wb_reg_wen;
    logic [4:0] d1_wb_rd, d0_wb_rd;
    logic [27:0] all1, all0;

    always #5 clk = ~clk;

    rv32_pipe_ctrl #(.FWD_EN(1'b1), .RA_W(5)) u_dut (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid), .brEq(brEq), .brLT(brLT),
        .id_imm_sel(d1_id_imm_sel), .id_illegal(d1_id_illegal), .ex_asel(d1_ex_asel),
        .ex_bsel(d1_ex_bsel), .ex_alu_sel(d1_ex_alu_sel), .ex_br_un(d1_ex_br_un),
        .fwd_a(d1_fwd_a), .fwd_b(d1_fwd_b), .pcSel(d1_pcSel), .stall_if(d1_stall_if),
        .flush_id(d1_flush_id), .mem_rw(d1_mem_rw), .mem_rd(d1_mem_rd), .wb_sel(d1_wb_sel),
        .wb_reg_wen(d1_wb_reg_wen), .wb_rd(d1_wb_rd)
    );

    rv32_pipe_ctrl #(.FWD_EN(1'b0), .RA_W(5)) u_dut0 (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid), .brEq(brEq), .brLT(brLT),
        .id_imm_sel(d0_id_imm_sel), .id_illegal(d0_id_illegal), .ex_asel(d0_ex_asel),
        .ex_bsel(d0_ex_bsel), .ex_alu_sel(d0_ex_alu_sel), .ex_br_un(d0_ex_br_un),
        .fwd_a(d0_fwd_a), .fwd_b(d0_fwd_b), .pcSel(d0_pcSel), .stall_if(d0_stall_if),
        .flush_id(d0_flush_id), .mem_rw(d0_mem_rw), .mem_rd(d0_mem_rd), .wb_sel(d0_wb_sel),
        .wb_reg_wen(d0_wb_reg_wen), .wb_rd(d0_wb_rd)
    );

    assign all1 = {d1_id_imm_sel, d1_id_illegal, d1_ex_asel, d1_ex_bsel, d1_ex_alu_sel, d1_ex_br_un,
                   d1_fwd_a, d1_fwd_b, d1_pcSel, d1_stall_if, d1_flush_id, d1_mem_rw, d1_mem_rd,
                   d1_wb_sel, d1_wb_reg_wen, d1_wb_rd};
    assign all0 = {d0_id_imm_sel, d0_id_illegal, d0_ex_asel, d0_ex_bsel, d0_ex_alu_sel, d0_ex_br_un,
                   d0_fwd_a, d0_fwd_b, d0_pcSel, d0_stall_if, d0_flush_id, d0_mem_rw, d0_mem_rd,
                   d0_wb_sel, d0_wb_reg_wen, d0_wb_rd};

    task automatic cyc(input logic [31:0] inst, input logic v);
        @(negedge clk);
        id_inst  = inst;
        id_valid = v;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) cyc(32'h0, 1'b0);
    endtask

    task automatic test_reset();
        #3;
        checks++; if (all1 !== 28'h0) begin errors++; $display("FAIL reset_init_fwd1: got %h exp 0", all1); end
        checks++; if (all0 !== 28'h0) begin errors++; $display("FAIL reset_init_fwd0: got %h exp 0", all0); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(I_LUI, 1'b1);
        checks++; if ({d1_wb_reg_wen, d1_wb_rd} !== 6'b1_00101) begin errors++; $display("FAIL reset_prefill_wb: got %b exp 100101", {d1_wb_reg_wen, d1_wb_rd}); end
        rst = 1'b1;
        #1;
        checks++; if (all1 !== 28'h0) begin errors++; $display("FAIL reset_async_fwd1: got %h exp 0", all1); end
        checks++; if (all0 !== 28'h0) begin errors++; $display("FAIL reset_async_fwd0: got %h exp 0", all0); end
        @(negedge clk);
        rst = 1'b0;
        id_valid = 1'b0;
        id_inst = 32'h0;
        for (int i = 0; i < 3; i++) begin
            cyc(32'h0, 1'b0);
            checks++; if (all1 !== 28'h0) begin errors++; $display("FAIL reset_bubble_%0d: got %h exp 0", i, all1); end
        end
    endtask

    task automatic test_load_use();
        drain();
        cyc(I_LW, 1'b1);
        cyc(I_ADD, 1'b1);
        checks++; if ({d1_stall_if, d0_stall_if} !== 2'b11) begin errors++; $display("FAIL lu_stall_first: got %b exp 11", {d1_stall_if, d0_stall_if}); end
        cyc(I_ADD, 1'b1);
        checks++; if (d1_stall_if !== 1'b0) begin errors++; $display("FAIL lu_stall_once: got %b exp 0", d1_stall_if); end
        checks++; if (d0_stall_if !== 1'b1) begin errors++; $display("FAIL lu_interlock_mem: got %b exp 1", d0_stall_if); end
        cyc(32'h0, 1'b0);
        checks++; if ({d1_fwd_a, d1_fwd_b} !== 4'b1000) begin errors++; $display("FAIL lu_fwd: got %b exp 1000", {d1_fwd_a, d1_fwd_b}); end
        checks++; if (d0_stall_if !== 1'b0) begin errors++; $display("FAIL lu_interlock_end: got %b exp 0", d0_stall_if); end
    endtask

    task automatic test_forwarding();
        drain();
        cyc(I_ADDI, 1'b1);
        cyc(I_ADD2, 1'b1);
        checks++; if ({d1_stall_if, d0_stall_if} !== 2'b01) begin errors++; $display("FAIL fwd_stall_c1: got %b exp 01", {d1_stall_if, d0_stall_if}); end
        cyc(I_ADD2, 1'b1);
        checks++; if ({d1_fwd_a, d1_fwd_b} !== 4'b0101) begin errors++; $display("FAIL fwd_mem: got %b exp 0101", {d1_fwd_a, d1_fwd_b}); end
        checks++; if (d0_stall_if !== 1'b1) begin errors++; $display("FAIL fwd0_stall_c2: got %b exp 1", d0_stall_if); end
        cyc(I_ADD2, 1'b1);
        checks++; if (d0_stall_if !== 1'b0) begin errors++; $display("FAIL fwd0_stall_c3: got %b exp 0", d0_stall_if); end
        cyc(32'h0, 1'b0);
        checks++; if ({d0_fwd_a, d0_fwd_b, d0_ex_bsel} !== 5'b00000) begin errors++; $display("FAIL fwd0_tied: got %b exp 00000", {d0_fwd_a, d0_fwd_b, d0_ex_bsel}); end
    endtask

    task automatic test_fwd_priority();
        drain();
        cyc(I_ADDI, 1'b1);
        cyc(I_ADDI, 1'b1);
        cyc(I_ADD2, 1'b1);
        cyc(32'h0, 1'b0);
        checks++; if ({d1_fwd_a, d1_fwd_b} !== 4'b0101) begin errors++; $display("FAIL fwd_prio_mem: got %b exp 0101", {d1_fwd_a, d1_fwd_b}); end
        drain();
        cyc(I_ADDI, 1'b1);
        cyc(32'h0, 1'b0);
        cyc(I_ADD2, 1'b1);
        cyc(32'h0, 1'b0);
        checks++; if ({d1_fwd_a, d1_fwd_b} !== 4'b1010) begin errors++; $display("FAIL fwd_wb: got %b exp 1010", {d1_fwd_a, d1_fwd_b}); end
    endtask

    task automatic test_branch_squash();
        logic [31:0] slot [2];
        slot = '{I_ADDI, I_SW};
        for (int k = 0; k < 2; k++) begin
            drain();
            brEq = 1'b1;
            cyc(I_BEQ, 1'b1);
            cyc(slot[k], 1'b1);
            checks++; if ({d1_pcSel, d1_flush_id, d1_stall_if, d0_flush_id} !== 4'b1101) begin errors++; $display("FAIL br_taken_%0d: got %b exp 1101", k, {d1_pcSel, d1_flush_id, d1_stall_if, d0_flush_id}); end
            for (int i = 0; i < 4; i++) begin
                cyc(32'h0, 1'b0);
                checks++; if ({d1_pcSel, d1_flush_id, d1_wb_reg_wen, d1_mem_rw} !== 4'b0000) begin errors++; $display("FAIL br_squash_%0d_%0d: got %b exp 0000", k, i, {d1_pcSel, d1_flush_id, d1_wb_reg_wen, d1_mem_rw}); end
            end
            brEq = 1'b0;
        end
    endtask

    task automatic test_branch_cond();
        typedef struct packed { logic [31:0] inst; logic eq; logic lt; logic pc; logic un; } bvec_t;
        bvec_t bv [7];
        bv = '{'{I_BEQ, 1'b0, 1'b0, 1'b0, 1'b0}, '{32'h00109463, 1'b0, 1'b0, 1'b1, 1'b0},
               '{32'h0010C463, 1'b0, 1'b1, 1'b1, 1'b0}, '{32'h0010D463, 1'b0, 1'b1, 1'b0, 1'b0},
               '{32'h0010E463, 1'b1, 1'b0, 1'b0, 1'b1}, '{32'h0010F463, 1'b1, 1'b0, 1'b1, 1'b1},
               '{32'h000000EF, 1'b0, 1'b0, 1'b1, 1'b0}};
        drain();
        for (int i = 0; i < 7; i++) begin
            cyc(bv[i].inst, 1'b1);
            cyc(32'h0, 1'b0);
            brEq = bv[i].eq;
            brLT = bv[i].lt;
            #1;
            checks++; if ({d1_pcSel, d1_ex_br_un} !== {bv[i].pc, bv[i].un}) begin errors++; $display("FAIL br_cond_%0d: got %b exp %b", i, {d1_pcSel, d1_ex_br_un}, {bv[i].pc, bv[i].un}); end
            cyc(32'h0, 1'b0);
        end
        brEq = 1'b0;
        brLT = 1'b0;
    endtask

    task automatic test_flush_vs_stall();
        drain();
        cyc(I_LW, 1'b1);
        cyc(I_BEQ, 1'b1);
        cyc(I_ADD, 1'b1);
        checks++; if ({d0_stall_if, d0_flush_id} !== 2'b10) begin errors++; $display("FAIL fvs_untaken: got %b exp 10", {d0_stall_if, d0_flush_id}); end
        brEq = 1'b1;
        #1;
        checks++; if ({d0_stall_if, d0_flush_id} !== 2'b01) begin errors++; $display("FAIL fvs_taken: got %b exp 01", {d0_stall_if, d0_flush_id}); end
        checks++; if ({d1_pcSel, d1_stall_if, d1_flush_id} !== 3'b101) begin errors++; $display("FAIL fvs_fwd1: got %b exp 101", {d1_pcSel, d1_stall_if, d1_flush_id}); end
        brEq = 1'b0;
    endtask

    task automatic test_decode();
        typedef struct packed { logic [31:0] inst; logic [2:0] imm; logic [5:0] ex; logic mrw; logic [2:0] wb; } dvec_t;
        dvec_t dv [8];
        dv = '{'{I_SW,         3'd1, 6'b010000, 1'b1, 3'b000},
               '{I_LUI,        3'd3, 6'b011111, 1'b0, 3'b011},
               '{32'h00001297, 3'd3, 6'b110000, 1'b0, 3'b011},
               '{32'h000000EF, 3'd4, 6'b110000, 1'b0, 3'b101},
               '{32'h402081B3, 3'd0, 6'b001000, 1'b0, 3'b011},
               '{32'h4020D193, 3'd0, 6'b011101, 1'b0, 3'b011},
               '{32'h4000F193, 3'd0, 6'b010111, 1'b0, 3'b011},
               '{I_BEQ,        3'd2, 6'b110000, 1'b0, 3'b000}};
        for (int i = 0; i < 8; i++) begin
            drain();
            cyc(dv[i].inst, 1'b1);
            checks++; if (d1_id_imm_sel !== dv[i].imm) begin errors++; $display("FAIL dec_imm_%0d: got %0d exp %0d", i, d1_id_imm_sel, dv[i].imm); end
            cyc(32'h0, 1'b0);
            checks++; if ({d1_ex_asel, d1_ex_bsel, d1_ex_alu_sel} !== dv[i].ex) begin errors++; $display("FAIL dec_ex_%0d: got %b exp %b", i, {d1_ex_asel, d1_ex_bsel, d1_ex_alu_sel}, dv[i].ex); end
            cyc(32'h0, 1'b0);
            checks++; if (d1_mem_rw !== dv[i].mrw) begin errors++; $display("FAIL dec_mem_%0d: got %b exp %b", i, d1_mem_rw, dv[i].mrw); end
            cyc(32'h0, 1'b0);
            checks++; if ({d1_wb_sel, d1_wb_reg_wen} !== dv[i].wb) begin errors++; $display("FAIL dec_wb_%0d: got %b exp %b", i, {d1_wb_sel, d1_wb_reg_wen}, dv[i].wb); end
        end
    endtask

    task automatic test_illegal();
        drain();
        cyc(I_BAD, 1'b0);
        checks++; if (d1_id_illegal !== 1'b0) begin errors++; $display("FAIL ill_novalid: got %b exp 0", d1_id_illegal); end
        id_valid = 1'b1;
        #1;
        checks++; if ({d1_id_illegal, d0_id_illegal} !== 2'b11) begin errors++; $display("FAIL ill_flag: got %b exp 11", {d1_id_illegal, d0_id_illegal}); end
        for (int i = 0; i < 3; i++) begin
            cyc(32'h0, 1'b0);
            checks++; if ({d1_wb_reg_wen, d1_mem_rw, d1_mem_rd, d1_ex_bsel} !== 4'b0000) begin errors++; $display("FAIL ill_nop_%0d: got %b exp 0000", i, {d1_wb_reg_wen, d1_mem_rw, d1_mem_rd, d1_ex_bsel}); end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_fwd_priority();
        test_branch_squash();
        test_branch_cond();
        test_flush_vs_stall();
        test_decode();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv32_pipe_ctrl.md
# rv32_pipe_ctrl

Pipelined control unit for the five-stage RV32I core. It decodes the instruction in ID into a control word and carries that word through the ID/EX, EX/MEM and MEM/WB registers. It resolves branches and jumps in EX and generates the stall, flush and forwarding controls. Parameter `FWD_EN` selects between a forwarding datapath and a full-interlock datapath.

## Interface
Parameters:
- `FWD_EN`, 1: 1 = forwarding muxes present, only load-use stalls; 0 = no forwarding, interlock on every RAW hazard against EX and MEM.
- `RA_W`, 5: register address width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_inst` in 32: instruction in ID.
- `id_valid` in 1: ID instruction is live.
- `brEq` in 1: EX comparator, rs1 == rs2.
- `brLT` in 1: EX comparator, rs1 < rs2, signedness per `ex_br_un`.
- `id_imm_sel` out 3: immediate type. I=0, S=1, B=2, U=3, J=4.
- `id_illegal` out 1: unsupported opcode in ID while `id_valid`.
- `ex_asel` out 1: ALU A source. 0 = rs1, 1 = PC.
- `ex_bsel` out 1: ALU B source. 0 = rs2, 1 = imm.
- `ex_alu_sel` out 4: ALU operation, `{funct7[5], funct3}`. Forced to ADD for load, store, AUIPC, JAL, JALR and branch.
- `ex_br_un` out 1: unsigned compare (BLTU, BGEU).
- `fwd_a` out 2: rs1 source. 0 = regfile, 1 = EX/MEM ALU result, 2 = WB data.
- `fwd_b` out 2: rs2 source, same encoding as `fwd_a`.
- `pcSel` out 1: 1 = redirect PC to the EX ALU result.
- `stall_if` out 1: hold PC and IF/ID.
- `flush_id` out 1: clear IF/ID to a bubble.
- `mem_rw` out 1: 1 = store.
- `mem_rd` out 1: load.
- `wb_sel` out 2: writeback source. 0 = mem, 1 = ALU, 2 = PC+4.
- `wb_reg_wen` out 1: regfile write enable.
- `wb_rd` out `RA_W`: writeback destination.

## Operation
- **Decode.** ID decodes opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP. Any other opcode gives a NOP word (all enables 0) and sets `id_illegal`. `rd == 0` forces RegWEn to 0.
- **Stage contents.** Each stage register holds `{valid, ctrl word, rd, rs1, rs2, funct3}`. A bubble means `valid = 0` with all enables cleared.
- **Branch and jump resolution (EX).** `pcSel` = valid & (JAL | JALR | (BRANCH & taken)).
  - BEQ: taken = `brEq`. BNE: taken = !`brEq`.
  - BLT and BLTU: taken = `brLT`. BGE and BGEU: taken = !`brLT`.
  - While `pcSel` is high: `flush_id` = 1, and ID/EX loads a bubble on the next edge.
- **Load-use hazard.** Condition: EX holds a valid load, ex_rd != 0, and ex_rd equals an rs1 or rs2 that the ID instruction actually uses.
  - Response: `stall_if` = 1, IF/ID holds, and ID/EX loads a bubble.
- **`FWD_EN` = 0.** The stall condition extends to any valid EX or MEM writer whose rd matches a used ID source. WB needs no check because the regfile is write-through. `fwd_a` and `fwd_b` are tied to 0.
- **`FWD_EN` = 1.** For each EX source with a nonzero address:
  - If it matches the MEM rd (RegWEn set), select 1.
  - Otherwise, if it matches the WB rd (RegWEn set), select 2.
  - Otherwise select 0. MEM has priority over WB.
- **Flush vs stall.** When both conditions hold in the same cycle, flush wins: `stall_if` = 0, `flush_id` = 1.
- **Reset.** Every stage goes to a bubble. All outputs are 0, including `pcSel`, `stall_if`, `flush_id`, `fwd_a`, `fwd_b`, `wb_rd` and `id_illegal`.
- **Reset mid-operation.** In-flight instructions are squashed with no writes. Outputs go to 0 asynchronously.

## Timing
- ID/EX, EX/MEM and MEM/WB advance on every clock edge. No stall is ever applied past ID.
- `id_*` outputs are combinational from `id_inst`.
- `ex_*`, `mem_*` and `wb_*` outputs come from registers and appear 1, 2 and 3 cycles after ID respectively.
- `pcSel`, `stall_if`, `flush_id`, `fwd_a` and `fwd_b` are combinational within the cycle. They come from stage registers, plus `brEq`/`brLT` for `pcSel`.
- Load-use penalty is 1 cycle. With `FWD_EN` = 0, a RAW hazard against EX costs 2 cycles and against MEM costs 1 cycle.
- Branch penalty is 2 cycles. Both the IF/ID and ID/EX slots are squashed.

## Structure
- Package `rv32_ctrl_pkg` holds:
  - the opcode constants;
  - the `imm_sel`, `wb_sel` and `fwd` encodings;
  - the ALU op encodings;
  - the `ctrl_word_t` packed struct;
  - `CTRL_NOP`.
- Sub-module `rv32_decode`: a purely combinational `id_inst` → `ctrl_word_t` decoder that also produces the `uses_rs1`, `uses_rs2` and `illegal` flags.
- Hazard and forwarding logic stays in the top level.

## Test plan
- **Reset.** Assert `rst` mid-stream → every output is 0 immediately. Bubbles continue for 3 cycles after release.
- **Load-use.** `lw x5,0(x1)` (0x0000A283) then `add x6,x5,x7` (0x00728333).
  - `stall_if` = 1 for exactly one cycle.
  - With `FWD_EN` = 1, the add reaches EX with `fwd_a` = 2.
- **Forwarding.** `addi x1,x0,1` (0x00100093) then `add x2,x1,x1` (0x00108133).
  - `FWD_EN` = 1: no stall, `fwd_a` = `fwd_b` = 1.
  - `FWD_EN` = 0: `stall_if` high for 2 cycles, `fwd_a` = `fwd_b` = 0.
- **Taken branch.** `beq x1,x1,+8` (0x00108463) with `brEq` = 1 in EX.
  - `pcSel` = 1 and `flush_id` = 1 for one cycle.
  - The next two instructions never assert `wb_reg_wen` or `mem_rw`.
- **Flush vs stall.** A taken branch in EX while ID holds a load-use consumer → `flush_id` = 1, `stall_if` = 0.
- **Illegal opcode.** `id_inst` = 0xFFFFFFFF with `id_valid` = 1.
  - `id_illegal` = 1.
  - Three cycles later, `wb_reg_wen` = 0 and `mem_rw` = 0.
